// File: rtl/rxuart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rxuart                                                       |
// | Description : 8-bit asynchronous serial receiver (start, 8 data LSB first, |
// |               optional even parity, stop). Mid-bit sampling driven by a    |
// |               per-bit down-counter; framing errors park the receiver in    |
// |               BREAK until the line returns high.                           |
// |               Optional feature macro: RXUART_PARITY_EN (even parity bit).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rxuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd139
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam logic [3:0] c_idle   = 4'd0;
  localparam logic [3:0] c_start  = 4'd1;
  localparam logic [3:0] c_bit0   = 4'd2;
  localparam logic [3:0] c_bit1   = 4'd3;
  localparam logic [3:0] c_bit2   = 4'd4;
  localparam logic [3:0] c_bit3   = 4'd5;
  localparam logic [3:0] c_bit4   = 4'd6;
  localparam logic [3:0] c_bit5   = 4'd7;
  localparam logic [3:0] c_bit6   = 4'd8;
  localparam logic [3:0] c_bit7   = 4'd9;
  localparam logic [3:0] c_parity = 4'd10;
  localparam logic [3:0] c_stop   = 4'd11;
  localparam logic [3:0] c_break  = 4'd12;

  // First sample lands mid start bit; later samples are one bit apart.
  localparam logic [23:0] c_half_m1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] c_full_m1 = CLOCKS_PER_BAUD - 24'd1;

  logic        sync1_q, rx_s_q;
  logic [3:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        wr_q, wr_d;
  logic        ferr_q, ferr_d;
  logic        w_sample;

  assign w_sample = (cnt_q == 24'd0);

  // State register and baud counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= c_idle;
      cnt_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter reload logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_idle: begin
        if (!rx_s_q) begin
          state_d = c_start;
          cnt_d   = c_half_m1;
        end
      end
      c_break: begin
        if (rx_s_q) state_d = c_idle;
      end
      c_start, c_bit0, c_bit1, c_bit2, c_bit3, c_bit4, c_bit5, c_bit6, c_bit7,
`ifdef RXUART_PARITY_EN
      c_parity,
`endif
      c_stop: begin
        if (w_sample) begin
          cnt_d = c_full_m1;
          case (state_q)
            c_start: begin
              // A high line mid start bit was a glitch, not a frame.
              if (rx_s_q) begin
                state_d = c_idle;
                cnt_d   = 24'd0;
              end else begin
                state_d = c_bit0;
              end
            end
`ifdef RXUART_PARITY_EN
            c_bit7:   state_d = c_parity;
            c_parity: state_d = c_stop;
`else
            c_bit7:   state_d = c_stop;
`endif
            c_stop: begin
              // Return to IDLE mid stop bit so a back-to-back start is caught.
              state_d = rx_s_q ? c_idle : c_break;
              cnt_d   = 24'd0;
            end
            default:  state_d = state_q + 4'd1;
          endcase
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: begin
        state_d = c_idle;
        cnt_d   = 24'd0;
      end
    endcase
  end

  // Datapath and strobe outputs derived from state and sample point.
  always_comb begin
    shift_d = shift_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    ferr_d  = 1'b0;
    o_busy  = (state_q != c_idle);
    if (w_sample && (state_q >= c_bit0) && (state_q <= c_bit7)) begin
      shift_d = {rx_s_q, shift_q[7:1]};
    end
    if (w_sample && (state_q == c_stop)) begin
      if (rx_s_q) begin
        data_d = shift_q;
        wr_d   = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  // Synchronizer, shift register and registered strobes.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= i_uart_rx;
      rx_s_q  <= sync1_q;
      shift_q <= shift_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_wr        = wr_q;
  assign o_data      = data_q;
  assign o_frame_err = ferr_q;

`ifdef RXUART_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;

  // Capture the parity bit; flag odd overall parity alongside a good stop bit.
  always_comb begin
    par_d  = par_q;
    perr_d = 1'b0;
    if (w_sample && (state_q == c_parity)) par_d = rx_s_q;
    if (w_sample && (state_q == c_stop) && rx_s_q) perr_d = ^{shift_q, par_q};
  end

  // Parity bit and parity error strobe registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rxuart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rxuart                                                    |
// | Description : Directed self-checking bench for rxuart at 16 clocks/bit.    |
// |               Honors RXUART_PARITY_EN for the parity frames.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rxuart;
  localparam int CPB = 16;
`ifdef RXUART_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       wr;
  logic [7:0] data;
  logic       busy;
  logic       ferr;
  logic       perr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int perr_lone = 0;
  int viol = 0;
  int fall_cyc = 0;
  int wr_cyc = 0;
  logic [7:0] log_q [0:31];
  logic wr_prev = 1'b0, ferr_prev = 1'b0, perr_prev = 1'b0;

  always #5 clk = ~clk;

  rxuart #(.CLOCKS_PER_BAUD(24'd16)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_uart_rx    (rx),
    .o_wr         (wr),
    .o_data       (data),
    .o_busy       (busy),
    .o_frame_err  (ferr),
    .o_parity_err (perr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: log received bytes and count pulses / protocol breaches.
  always @(negedge clk) begin
    if (wr) begin
      if (wr_cnt < 32) log_q[wr_cnt] = data;
      wr_cnt = wr_cnt + 1;
      wr_cyc = cyc;
    end
    if (ferr) ferr_cnt = ferr_cnt + 1;
    if (perr) perr_cnt = perr_cnt + 1;
    if (perr && !wr) perr_lone = perr_lone + 1;
    if (wr && ferr) viol = viol + 1;
    if ((wr && wr_prev) || (ferr && ferr_prev) || (perr && perr_prev)) viol = viol + 1;
    wr_prev   = wr;
    ferr_prev = ferr;
    perr_prev = perr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RXUART_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef RXUART_PARITY_EN
  task automatic send_byte_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  initial begin
    int lat;
    logic [7:0] b96;
    b96 = 8'h96;

    // Reset with idle line.
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_wr",   {31'd0, wr},   32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_perr", {31'd0, perr}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single good frame.
    send_byte(8'h55, 1'b1);
    idle(40);
    lat = wr_cyc - fall_cyc;
    check("f55_wr_cnt", wr_cnt, 32'd1);
    check("f55_data", {24'd0, data}, 32'h55);
    check("f55_ferr_cnt", ferr_cnt, 32'd0);
    check("f55_busy", {31'd0, busy}, 32'd0);
    check("f55_latency_ok", {31'd0, (lat >= LAT - 1) && (lat <= LAT + 1)}, 32'd1);

    // False start: 4 clocks low.
    rx = 1'b0;
    idle(4);
    check("fs_busy_hi", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    idle(8);
    check("fs_busy_lo", {31'd0, busy}, 32'd0);
    check("fs_wr_cnt", wr_cnt, 32'd1);
    check("fs_ferr_cnt", ferr_cnt, 32'd0);

    // Framing error, then break held low.
    send_byte(8'hA3, 1'b0);
    idle(40);
    check("fe_ferr_cnt", ferr_cnt, 32'd1);
    check("fe_wr_cnt", wr_cnt, 32'd1);
    check("fe_data_kept", {24'd0, data}, 32'h55);
    check("fe_busy_break", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    idle(10);
    check("fe_busy_lo", {31'd0, busy}, 32'd0);
    send_byte(8'h3C, 1'b1);
    idle(20);
    check("f3c_wr_cnt", wr_cnt, 32'd2);
    check("f3c_data", {24'd0, log_q[1]}, 32'h3C);

    // Back-to-back frames without idle gap.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    idle(20);
    check("b2b_wr_cnt", wr_cnt, 32'd5);
    check("b2b_d0", {24'd0, log_q[2]}, 32'h00);
    check("b2b_d1", {24'd0, log_q[3]}, 32'hFF);
    check("b2b_d2", {24'd0, log_q[4]}, 32'h81);

    // Reset pulse in the middle of BIT4; sender abandons the frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b96[i]);
    rx = b96[4];
    idle(8);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_data", {24'd0, data}, 32'd0);
    check("mr_wr",   {31'd0, wr},   32'd0);
    check("mr_ferr", {31'd0, ferr}, 32'd0);
    rst_n = 1'b1;
    rx = 1'b1;
    idle(200);
    check("mr_no_wr", wr_cnt, 32'd5);
    send_byte(8'h5A, 1'b1);
    idle(20);
    check("f5a_wr_cnt", wr_cnt, 32'd6);
    check("f5a_data", {24'd0, data}, 32'h5A);

`ifdef RXUART_PARITY_EN
    // Bad parity on 0xA5 (even parity is 0), then good parity.
    send_byte_par(8'hA5, 1'b1);
    idle(20);
    check("pe_wr_cnt", wr_cnt, 32'd7);
    check("pe_data", {24'd0, data}, 32'hA5);
    check("pe_perr_cnt", perr_cnt, 32'd1);
    send_byte_par(8'hA5, 1'b0);
    idle(20);
    check("pok_wr_cnt", wr_cnt, 32'd8);
    check("pok_perr_cnt", perr_cnt, 32'd1);
    check("perr_without_wr", perr_lone, 32'd0);
`else
    check("perr_cnt_zero", perr_cnt, 32'd0);
`endif

    check("strobe_rules", viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rxuart.md
RXUART -- requirements
Module: rxuart

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, 24 bits, default 24'd139 (115200 baud at 16 MHz), clocks per bit period; legal range 4..2^24-1.
REQ-002 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_uart_rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port o_wr  output  1  one-cycle strobe: o_data holds a newly received byte.
REQ-006 SHALL have port o_data  output  8  last received byte, held until the next o_wr.
REQ-007 SHALL have port o_busy  output  1  high whenever the state machine is not IDLE.
REQ-008 SHALL have port o_frame_err  output  1  one-cycle strobe: stop bit sampled low.
REQ-009 SHALL have port o_parity_err  output  1  one-cycle strobe: parity mismatch (see Configuration).

Function
REQ-010 SHALL pass i_uart_rx through a 2-flop synchronizer, both flops reset to 1; all decisions use the second flop (rx_s).
REQ-011 SHALL have states IDLE, START, BIT0..BIT7, PARITY (macro only), STOP, BREAK.
REQ-012 IDLE: when rx_s==0, load the baud counter with CLOCKS_PER_BAUD/2-1 (integer division) and go to START.
REQ-013 Counter SHALL decrement by 1 each cycle outside IDLE/BREAK; "sample point" = cycle on which counter==0; on each sample point it reloads with CLOCKS_PER_BAUD-1 unless going to IDLE or BREAK.
REQ-014 START sample point: rx_s==1 -> false start, return to IDLE with no strobe; rx_s==0 -> BIT0.
REQ-015 BITn sample point: shift rx_s in LSB first (shift register right, new bit into bit 7); BIT7 goes to PARITY if enabled, else STOP.
REQ-016 STOP sample point, rx_s==1: o_data <= shift register, o_wr=1 on the next cycle for exactly one cycle, go to IDLE (re-armed ~half a bit early for back-to-back frames).
REQ-017 STOP sample point, rx_s==0: o_data unchanged, no o_wr, o_frame_err=1 for one cycle, go to BREAK.
REQ-018 BREAK: stay until rx_s==1, then IDLE; no strobes while in BREAK.
REQ-019 o_wr, o_frame_err, o_parity_err SHALL be registered, never high for more than one consecutive cycle, and o_wr and o_frame_err never high together.
REQ-020 Latency: o_wr rises 1 cycle after the stop-bit sample point, i.e. 2 (sync) + CLOCKS_PER_BAUD/2 + 9*CLOCKS_PER_BAUD (+CLOCKS_PER_BAUD with parity) + 1 cycles after i_uart_rx falls, +/-1 for sync alignment.
REQ-021 A falling edge on i_uart_rx while not in IDLE SHALL be ignored.

Reset
REQ-022 While i_reset_n==0 at a rising edge: state=IDLE, counter=0, synchronizer flops=1, shift register=0, o_data=8'h00, o_wr=0, o_busy=0, o_frame_err=0, o_parity_err=0.
REQ-023 Reset mid-frame SHALL abort the frame with no strobe; a frame whose start bit began before reset release SHALL NOT produce o_wr unless the line is low at the first IDLE cycle (then treated as a new start).

Configuration
REQ-024 Macro RXUART_PARITY_EN defined: one even-parity bit follows BIT7 (state PARITY, sampled like a data bit); at the stop-bit sample, if XOR(data, parity bit)!=0, o_parity_err=1 in the same cycle as o_wr (o_wr still issued); with a framing error, o_parity_err stays 0.
REQ-025 Macro RXUART_PARITY_EN not defined: frame = start + 8 data + stop, no PARITY state, o_parity_err tied to 0.

Verification (CLOCKS_PER_BAUD=16 unless stated)
REQ-026 Reset, idle line, then frame 0x55 with stop=1 -> exactly one o_wr pulse, o_data=8'h55, o_frame_err=0, o_busy low afterwards.
REQ-027 Line low for 4 clocks then high -> START rejects at sample point, no o_wr/o_frame_err, o_busy back to 0 within 8 clocks.
REQ-028 Frame 0xA3 with stop bit 0, line held low 40 clocks -> o_frame_err one pulse, no o_wr, o_data unchanged, state BREAK until line high, then next frame 0x3C received correctly.
REQ-029 Frames 0x00, 0xFF, 0x81 back-to-back with no idle gap -> three o_wr pulses, o_data 8'h00, 8'hFF, 8'h81 in order.
REQ-030 i_reset_n low for 1 cycle during BIT4 of 0x96 -> no o_wr for that frame, all outputs at reset values, next frame 0x5A received.
REQ-031 With RXUART_PARITY_EN, 0xA5 with parity bit 1 -> o_wr with o_data=8'hA5 and o_parity_err=1 same cycle; parity bit 0 -> o_parity_err=0.
